div_iter: RTL and testbench

- Parametrised iterative integer divider for the execute stage; successor to the current 32-bit divide unit.
- Supports DIV/DIVU/REM/REMU (fu_op_t) at WIDTH 32 or 64.
- WIDTH=64 adds word mode (RV64 *W ops) with 32-bit operation and sign-extended result.
- Radix-2 restoring core with leading-zero skip, early-out special cases, and a full valid/ready handshake on the result side (result held under backpressure).

---
 rtl/div_iter.sv | 199 +++++++++++++++++++
 tb/tb_div_iter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Iterative radix-2 restoring integer divider (DIV/DIVU/REM/REMU) with leading-zero skip,
// early-out special cases and an optional RV64 word mode.
package div_iter_pkg;
    typedef enum logic [1:0] {DIV, DIVU, REM, REMU} fu_op_t;
endpackage

module div_iter
    import div_iter_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDR_BITS = 4,
    parameter bit          WORD_EN   = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_ex_i,
    input  logic                 div_vld_i,
    output logic                 div_rdy_o,
    input  fu_op_t               op_i,
    input  logic                 word_i,
    input  logic [WIDTH-1:0]     op1_i,
    input  logic [WIDTH-1:0]     op2_i,
    input  logic [ADDR_BITS-1:0] trans_id_i,
    output logic                 res_vld_o,
    input  logic                 res_rdy_i,
    output logic [ADDR_BITS-1:0] trans_id_o,
    output logic [WIDTH-1:0]     div_result_o,
    output logic                 busy_o
);

    localparam int unsigned      CntW   = $clog2(WIDTH) + 1;
    localparam bit               WordOk = WORD_EN && (WIDTH == 64);
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     q_q, q_d, r_q, r_d, b_q, b_d, res_q, res_d;
    logic                 q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic                 rem_q, rem_d, word_q, word_d;
    logic [ADDR_BITS-1:0] tag_q, tag_d;

    logic                 is_signed, is_rem, word_mode, a_neg, b_neg;
    logic                 div_zero, ovf, a_lt_b, found;
    logic [WIDTH-1:0]     a_ext, b_ext, a_mag, b_mag, a_norm;
    logic [WIDTH-1:0]     early_q, early_r, early_res;
    logic [CntW-1:0]      a_clz, n_steps;
    logic [WIDTH:0]       r_shift;
    logic                 r_ge;
    logic [WIDTH-1:0]     r_step, q_step, q_fix, r_fix;

    // Word results are the low 32 bits sign-extended, for signed and unsigned ops alike.
    function automatic logic [WIDTH-1:0] finalize(input logic [WIDTH-1:0] val, input logic word);
        return word ? WIDTH'($signed(val[31:0])) : val;
    endfunction

    always_comb begin
        is_signed = (op_i == DIV) || (op_i == REM);
        is_rem    = (op_i == REM) || (op_i == REMU);
        word_mode = WordOk && word_i;
        a_ext     = op1_i;
        b_ext     = op2_i;
        if (word_mode) begin
            if (is_signed) begin
                a_ext = WIDTH'($signed(op1_i[31:0]));
                b_ext = WIDTH'($signed(op2_i[31:0]));
            end else begin
                a_ext = WIDTH'(op1_i[31:0]);
                b_ext = WIDTH'(op2_i[31:0]);
            end
        end
        a_neg    = is_signed && a_ext[WIDTH-1];
        b_neg    = is_signed && b_ext[WIDTH-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        ovf      = is_signed && (b_ext == '1) &&
                   (word_mode ? (a_ext[31:0] == 32'h8000_0000) : (a_ext == MinNeg));
        a_lt_b   = a_mag < b_mag;

        a_clz = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (a_mag[i]) found = 1'b1;
                else          a_clz = a_clz + 1'b1;
            end
        end
        n_steps = CntW'(WIDTH) - a_clz;
        a_norm  = a_mag << a_clz;

        if (div_zero) begin
            early_q = '1;
            early_r = a_ext;
        end else if (ovf) begin
            early_q = a_ext;
            early_r = '0;
        end else begin
            early_q = '0;
            early_r = a_ext;
        end
        early_res = finalize(is_rem ? early_r : early_q, word_mode);
    end

    // One restoring step; the partial remainder always fits WIDTH bits after subtraction.
    always_comb begin
        r_shift = {r_q, q_q[WIDTH-1]};
        r_ge    = r_shift >= {1'b0, b_q};
        r_step  = r_ge ? (r_shift[WIDTH-1:0] - b_q) : r_shift[WIDTH-1:0];
        q_step  = {q_q[WIDTH-2:0], r_ge};
        q_fix   = q_neg_q ? -q_step : q_step;
        r_fix   = r_neg_q ? -r_step : r_step;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        b_d     = b_q;
        res_d   = res_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        rem_d   = rem_q;
        word_d  = word_q;
        tag_d   = tag_q;
        unique case (state_q)
            StIdle: begin
                if (div_vld_i) begin
                    tag_d   = trans_id_i;
                    rem_d   = is_rem;
                    word_d  = word_mode;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    b_d     = b_mag;
                    if (div_zero || ovf || a_lt_b) begin
                        res_d   = early_res;
                        state_d = StDone;
                    end else begin
                        q_d     = a_norm;
                        r_d     = '0;
                        cnt_d   = n_steps;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                q_d   = q_step;
                r_d   = r_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    res_d   = finalize(rem_q ? r_fix : q_fix, word_q);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (res_rdy_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (flush_ex_i) state_d = StIdle;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            rem_q   <= 1'b0;
            word_q  <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            b_q     <= b_d;
            res_q   <= res_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
            tag_q   <= tag_d;
        end
    end

    assign div_rdy_o    = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign res_vld_o    = (state_q == StDone);
    assign trans_id_o   = tag_q;
    assign div_result_o = res_vld_o ? res_q : '0;

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: directed vector table, multi-cycle corner sequences and randomized
// operations against an arithmetic reference model, on a 32-bit and a 64-bit word-mode instance.
module tb_div_iter;
    import div_iter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, res_rdy, word, vld32, vld64, sel;
    fu_op_t      op;
    logic [63:0] op1, op2;
    logic [3:0]  tag;
    logic        rdy32, rdy64, rv32, rv64, busy32, busy64;
    logic [3:0]  tid32, tid64;
    logic [31:0] res32;
    logic [63:0] res64;

    logic        cur_rdy, cur_vld, cur_busy;
    logic [3:0]  cur_tid;
    logic [63:0] cur_res;

    int checks = 0;
    int failures = 0;

    div_iter #(.WIDTH(32), .ADDR_BITS(4), .WORD_EN(1'b0)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_ex_i(flush), .div_vld_i(vld32), .div_rdy_o(rdy32),
        .op_i(op), .word_i(word), .op1_i(op1[31:0]), .op2_i(op2[31:0]), .trans_id_i(tag),
        .res_vld_o(rv32), .res_rdy_i(res_rdy), .trans_id_o(tid32), .div_result_o(res32),
        .busy_o(busy32)
    );

    div_iter #(.WIDTH(64), .ADDR_BITS(4), .WORD_EN(1'b1)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_ex_i(flush), .div_vld_i(vld64), .div_rdy_o(rdy64),
        .op_i(op), .word_i(word), .op1_i(op1), .op2_i(op2), .trans_id_i(tag),
        .res_vld_o(rv64), .res_rdy_i(res_rdy), .trans_id_o(tid64), .div_result_o(res64),
        .busy_o(busy64)
    );

    assign cur_rdy  = sel ? rdy64 : rdy32;
    assign cur_vld  = sel ? rv64 : rv32;
    assign cur_busy = sel ? busy64 : busy32;
    assign cur_tid  = sel ? tid64 : tid32;
    assign cur_res  = sel ? res64 : {32'd0, res32};

    typedef struct {
        bit          s;
        fu_op_t      o;
        bit          w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic plus the architectural special cases.
    function automatic logic [63:0] model(input bit s, input fu_op_t o, input bit w,
                                          input logic [63:0] a, input logic [63:0] b,
                                          output int lat);
        bit          w32, sgn, isr;
        logic [63:0] ua, ub, q, r, res, ma, mb, minneg;
        w32 = !s || w;
        sgn = (o == DIV) || (o == REM);
        isr = (o == REM) || (o == REMU);
        if (w32) begin
            ua     = sgn ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
            ub     = sgn ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
            minneg = 64'hFFFF_FFFF_8000_0000;
        end else begin
            ua     = a;
            ub     = b;
            minneg = 64'h8000_0000_0000_0000;
        end
        ma = (sgn && ua[63]) ? -ua : ua;
        mb = (sgn && ub[63]) ? -ub : ub;
        lat = 1;
        if (ub == 64'd0) begin
            q = '1;
            r = ua;
        end else if (sgn && ua == minneg && ub == '1) begin
            q = ua;
            r = 64'd0;
        end else begin
            if (sgn) begin
                q = $signed(ua) / $signed(ub);
                r = $signed(ua) % $signed(ub);
            end else begin
                q = ua / ub;
                r = ua % ub;
            end
            if (ma >= mb) begin
                while (ma != 64'd0) begin
                    ma = ma >> 1;
                    lat++;
                end
            end
        end
        res = isr ? r : q;
        if (w32) res = s ? {{32{res[31]}}, res[31:0]} : {32'd0, res[31:0]};
        return res;
    endfunction

    function automatic logic [63:0] pick();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = 64'd0;
            1:       v = '1;
            2:       v = 64'h8000_0000_0000_0000;
            3:       v = 64'hFFFF_FFFF_8000_0000;
            4:       v = 64'($urandom_range(1, 20));
            5:       v = -64'($urandom_range(1, 20));
            default: v = {$urandom, $urandom} >> $urandom_range(0, 63);
        endcase
        return v;
    endfunction

    // Issues one request and waits (bounded) for res_vld_o; returns on the negedge it is seen.
    task automatic run(input bit s, input fu_op_t o, input bit w, input logic [63:0] a,
                       input logic [63:0] b, input logic [3:0] t, output int lat);
        bit done;
        @(negedge clk);
        sel  = s;
        op   = o;
        word = w;
        op1  = a;
        op2  = b;
        tag  = t;
        if (s) vld64 = 1'b1;
        else   vld32 = 1'b1;
        check("req_ready", 64'(cur_rdy), 64'd1);
        @(posedge clk);
        #1;
        vld32 = 1'b0;
        vld64 = 1'b0;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (cur_vld) done = 1'b1;
            else         check("res_zero_when_invalid", cur_res, 64'd0);
        end
    endtask

    task automatic take();
        res_rdy = 1'b1;
        @(posedge clk);
        #1;
        res_rdy = 1'b0;
        @(negedge clk);
        check("rdy_after_take", 64'(cur_rdy), 64'd1);
        check("vld_after_take", 64'(cur_vld), 64'd0);
    endtask

    initial begin
        vec_t        vecs[16];
        int          lat, elat, seen;
        logic [63:0] exp, held_res;
        logic [3:0]  held_tid, t;
        bit          s, w;
        fu_op_t      o;
        logic [63:0] a, b;

        vecs[0]  = '{1'b0, DIV,  1'b0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 4};
        vecs[1]  = '{1'b0, REM,  1'b0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 4};
        vecs[2]  = '{1'b0, DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF, 1};
        vecs[3]  = '{1'b0, REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1};
        vecs[4]  = '{1'b0, DIV,  1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1};
        vecs[5]  = '{1'b0, REM,  1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1};
        vecs[6]  = '{1'b0, DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 8};
        vecs[7]  = '{1'b0, DIVU, 1'b0, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF, 33};
        vecs[8]  = '{1'b0, DIVU, 1'b0, 64'd3, 64'd9, 64'd0, 1};
        vecs[9]  = '{1'b1, DIV,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'hAAAA_0000_0000_0002,
                     64'hFFFF_FFFF_FFFF_FFFD, 4};
        vecs[10] = '{1'b1, REMU, 1'b1, 64'h0000_0000_8000_0000, 64'd3, 64'd2, 33};
        vecs[11] = '{1'b1, DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1,
                     64'hFFFF_FFFF_FFFF_FFFE, 33};
        vecs[12] = '{1'b1, DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                     64'hFFFF_FFFF_FFFF_FFFF, 65};
        vecs[13] = '{1'b1, REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFF, 4};
        vecs[14] = '{1'b1, DIV,  1'b0, 64'h8000_0000_0000_0000, '1,
                     64'h8000_0000_0000_0000, 1};
        vecs[15] = '{1'b1, REM,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                     64'd0, 1};

        rst_n   = 1'b0;
        flush   = 1'b0;
        res_rdy = 1'b0;
        word    = 1'b0;
        vld32   = 1'b0;
        vld64   = 1'b0;
        sel     = 1'b0;
        op      = DIV;
        op1     = '0;
        op2     = '0;
        tag     = '0;
        #12;
        for (int i = 0; i < 2; i++) begin
            sel = i[0];
            #1;
            check("reset_rdy", 64'(cur_rdy), 64'd1);
            check("reset_vld", 64'(cur_vld), 64'd0);
            check("reset_busy", 64'(cur_busy), 64'd0);
            check("reset_tid", 64'(cur_tid), 64'd0);
            check("reset_res", cur_res, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run(vecs[i].s, vecs[i].o, vecs[i].w, vecs[i].a, vecs[i].b, 4'(i), lat);
            check($sformatf("vec%0d_result", i), cur_res, vecs[i].exp);
            check($sformatf("vec%0d_tid", i), 64'(cur_tid), 64'(i));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            take();
        end

        // Backpressure: result and tag held while res_rdy_i stays low.
        run(1'b0, DIVU, 1'b0, 64'd100, 64'd7, 4'hA, lat);
        held_res = cur_res;
        held_tid = cur_tid;
        check("bp_result", held_res, 64'd14);
        repeat (5) begin
            @(negedge clk);
            check("bp_vld_held", 64'(cur_vld), 64'd1);
            check("bp_res_held", cur_res, 64'd14);
            check("bp_tid_held", 64'(cur_tid), 64'hA);
            check("bp_rdy_low", 64'(cur_rdy), 64'd0);
        end
        take();

        // Flush in the fourth BUSY step drops the operation.
        @(negedge clk);
        sel   = 1'b0;
        op    = DIVU;
        op1   = 64'hFFFF_FFFF;
        op2   = 64'd1;
        tag   = 4'h5;
        vld32 = 1'b1;
        @(posedge clk);
        #1;
        vld32 = 1'b0;
        repeat (4) @(negedge clk);
        check("flush_busy_before", 64'(cur_busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_idle", 64'(cur_busy), 64'd0);
        check("flush_rdy", 64'(cur_rdy), 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (cur_vld) seen++;
        end
        check("flush_no_result", 64'(seen), 64'd0);
        run(1'b0, DIV, 1'b0, 64'hFFFF_FFF9, 64'd2, 4'h6, lat);
        check("post_flush_result", cur_res, 64'hFFFF_FFFD);
        check("post_flush_latency", 64'(lat), 64'd4);
        take();

        // Flush coincident with accept: request dropped.
        @(negedge clk);
        op    = DIVU;
        op1   = 64'd5;
        op2   = 64'd0;
        vld32 = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        vld32 = 1'b0;
        flush = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (cur_vld || cur_busy) seen++;
        end
        check("flush_accept_dropped", 64'(seen), 64'd0);

        // Flush coincident with res_rdy_i in DONE returns to IDLE.
        run(1'b0, DIVU, 1'b0, 64'd3, 64'd9, 4'h3, lat);
        res_rdy = 1'b1;
        flush   = 1'b1;
        @(posedge clk);
        #1;
        res_rdy = 1'b0;
        flush   = 1'b0;
        @(negedge clk);
        check("flush_done_idle", 64'(cur_busy), 64'd0);
        check("flush_done_vld", 64'(cur_vld), 64'd0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        sel   = 1'b1;
        op    = DIVU;
        word  = 1'b0;
        op1   = '1;
        op2   = 64'd3;
        tag   = 4'hC;
        vld64 = 1'b1;
        @(posedge clk);
        #1;
        vld64 = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 64'(cur_busy), 64'd0);
        check("midreset_rdy", 64'(cur_rdy), 64'd1);
        check("midreset_tid", 64'(cur_tid), 64'd0);
        check("midreset_vld", 64'(cur_vld), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            s = 1'($urandom_range(0, 1));
            o = fu_op_t'($urandom_range(0, 3));
            w = s ? 1'($urandom_range(0, 1)) : 1'b0;
            a = pick();
            b = pick();
            t = 4'($urandom);
            exp = model(s, o, w, a, b, elat);
            run(s, o, w, a, b, t, lat);
            check($sformatf("rand%0d_result op=%0d w=%0d a=%0h b=%0h", i, o, w, a, b),
                  cur_res, exp);
            check($sformatf("rand%0d_tid", i), 64'(cur_tid), 64'(t));
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'(elat));
            take();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
